dds_freq_meter: RTL and testbench

- Measures the frequency of a 1-bit square wave, such as a DDS MSB output, and reports the equivalent 32-bit frequency tuning word K.
- Lets the bench or a host loop close on the DDS generator: K_est ≈ f_in·2^32/f_clk.
- Counts rising edges over a power-of-two gate window, so K_est is a plain left shift with no divider.
- Also reports the clock-cycle period of the most recent full input cycle.

---
 rtl/dds_freq_meter.sv | 142 ++++++++++++++
 tb/tb_dds_freq_meter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_freq_meter.sv
// dds_freq_meter
//   Measures the frequency of a 1-bit square wave and reports it as a 32-bit
//   DDS frequency tuning word. Rising edges are counted over a gate window of
//   2^GATE_LOG2 clk cycles. The gate is aligned to the first rising edge seen
//   after arming, so the tuning word is simply the edge count shifted left.
//   The clk-cycle period of the most recent full input cycle is also reported.
//
// Ports
//   clk        system clock (same clock as the DDS phase accumulator)
//   rst        synchronous active-high reset
//   start      one-cycle request for a single measurement; ignored while busy
//   continuous level; while high, measurements re-arm after every result
//   sig_in     measured square wave; may be asynchronous to clk
//   busy       high while a measurement is in progress (ARM, GATE, DONE)
//   valid      one-cycle pulse when the result outputs update
//   no_signal  last measurement timed out waiting for an arming edge
//   edge_cnt   rising edges counted in the last gate window
//   k_est      edge_cnt << (32-GATE_LOG2), truncated to 32 bits
//   period     clk cycles between the last two rising edges (saturating)
module dds_freq_meter #(
  parameter int GATE_LOG2 = 8,
  parameter int PER_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 sig_in,
  output logic                 busy,
  output logic                 valid,
  output logic                 no_signal,
  output logic [GATE_LOG2:0]   edge_cnt,
  output logic [31:0]          k_est,
  output logic [PER_W-1:0]     period
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  localparam logic [GATE_LOG2-1:0] CNT_LAST = '1;
  localparam logic [PER_W-1:0]     PER_MAX  = '1;

  state_t                 state, state_nxt;
  logic                   s1, s2, s3;
  logic                   rise;
  logic [GATE_LOG2-1:0]   tmo_cnt;
  logic [GATE_LOG2-1:0]   gate_cnt;
  logic [GATE_LOG2:0]     edge_acc;
  logic                   to_flag;
  logic [PER_W-1:0]       per_cnt;
  logic [PER_W-1:0]       per_cap;
  logic [PER_W-1:0]       per_inc;
  logic [GATE_LOG2:0]     done_cnt;
  logic [31:0]            done_k;

  assign rise    = s2 & ~s3;
  assign busy    = (state != IDLE);
  assign per_inc = (per_cnt == PER_MAX) ? per_cnt : per_cnt + 1'b1;

  // Result values as loaded in DONE; a timeout forces a zero count.
  assign done_cnt = to_flag ? '0 : edge_acc;
  assign done_k   = {{(31-GATE_LOG2){1'b0}}, done_cnt} << (32 - GATE_LOG2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start || continuous) state_nxt = ARM;
      ARM: begin
        if (rise)                    state_nxt = GATE;
        else if (tmo_cnt == CNT_LAST) state_nxt = DONE;
      end
      GATE: if (gate_cnt == CNT_LAST) state_nxt = DONE;
      DONE: state_nxt = continuous ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      tmo_cnt   <= '0;
      gate_cnt  <= '0;
      edge_acc  <= '0;
      to_flag   <= 1'b0;
      per_cnt   <= '0;
      per_cap   <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b0;
      edge_cnt  <= '0;
      k_est     <= '0;
      period    <= '0;
    end else begin
      state <= state_nxt;
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;

      // Period counter only runs while measuring and holds through DONE.
      if (state == ARM || state == GATE) begin
        if (rise) begin
          per_cap <= per_inc;
          per_cnt <= '0;
        end else begin
          per_cnt <= per_inc;
        end
      end else if (state == IDLE) begin
        per_cnt <= '0;
      end

      case (state)
        IDLE: tmo_cnt <= '0;
        ARM: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (rise) begin
            gate_cnt <= '0;
            edge_acc <= '0;
          end else if (tmo_cnt == CNT_LAST) begin
            to_flag <= 1'b1;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          if (rise) edge_acc <= edge_acc + 1'b1;
        end
        DONE: begin
          edge_cnt  <= done_cnt;
          k_est     <= done_k;
          period    <= to_flag ? '0 : per_cap;
          no_signal <= to_flag;
          valid     <= 1'b1;
          to_flag   <= 1'b0;
          tmo_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Self-checking bench for dds_freq_meter. A periodic square wave of a chosen
// period is generated; expected results come from the measurement definition:
// a window of 2^G cycles starting after the arming edge holds floor(2^G/P)
// further edges, and the period equals P.
module tb_dds_freq_meter;
  localparam int G   = 8;
  localparam int PW  = 32;
  localparam int WIN = 1 << G;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          sig_in = 1'b0;
  logic          busy, valid, no_signal;
  logic [G:0]    edge_cnt;
  logic [31:0]   k_est;
  logic [PW-1:0] period;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sig_mode = 0;
  int sig_period = 16;
  int ph = 0;

  dds_freq_meter #(.GATE_LOG2(G), .PER_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sig_in(sig_in), .busy(busy), .valid(valid), .no_signal(no_signal),
    .edge_cnt(edge_cnt), .k_est(k_est), .period(period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave source: high for the first half of each period.
  initial forever begin
    @(posedge clk);
    #1;
    if (sig_mode == 1) begin
      sig_in = (ph < sig_period / 2);
      ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [G:0] exp_edges(input int p);
    return (G+1)'(WIN / p);
  endfunction

  function automatic logic [31:0] exp_k(input int e);
    longint v;
    v = longint'(e) * (longint'(1) << (32 - G));
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_periodic(input int p);
    @(negedge clk);
    sig_period = p;
    ph = 0;
    sig_mode = 1;
  endtask

  task automatic set_level(input logic b);
    @(negedge clk);
    sig_mode = 0;
    sig_in = b;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({busy, valid, no_signal, edge_cnt, k_est, period} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b valid=%b ns=%b edge=%0d k=%h per=%0d, expected all 0",
               busy, valid, no_signal, edge_cnt, k_est, period);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit seen;
    set_periodic(16);
    repeat (20) tick();
    pulse_start();
    wait_valid(3 * WIN, seen);
    vectors++;
    if (!seen || {edge_cnt, k_est, period, no_signal} !== {exp_edges(16), exp_k(16), PW'(16), 1'b0}) begin
      miscompares++;
      $display("FAIL single_p16: seen=%b edge=%0d k=%h per=%0d ns=%b, expected edge=%0d k=%h per=16 ns=0",
               seen, edge_cnt, k_est, period, no_signal, exp_edges(16), exp_k(16));
    end
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after: valid=%b busy=%b, expected 0 0", valid, busy);
    end
  endtask

  task automatic test_no_signal();
    bit seen;
    int e1;
    set_level(1'b0);
    repeat (5) tick();
    e1 = cyc + 1;
    pulse_start();
    wait_valid(2 * WIN, seen);
    vectors++;
    if (!seen || (cyc - e1) !== WIN + 1) begin
      miscompares++;
      $display("FAIL timeout_latency: seen=%b latency=%0d, expected %0d", seen, cyc - e1, WIN + 1);
    end
    vectors++;
    if ({edge_cnt, k_est, period, no_signal} !== {(G+1)'(0), 32'h0, PW'(0), 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_result: edge=%0d k=%h per=%0d ns=%b, expected 0 0 0 1",
               edge_cnt, k_est, period, no_signal);
    end
    set_periodic(16);
    repeat (10) tick();
    pulse_start();
    wait_valid(3 * WIN, seen);
    vectors++;
    if (!seen || {edge_cnt, k_est, period, no_signal} !== {exp_edges(16), exp_k(16), PW'(16), 1'b0}) begin
      miscompares++;
      $display("FAIL recover_after_timeout: seen=%b edge=%0d k=%h per=%0d ns=%b, expected %0d %h 16 0",
               seen, edge_cnt, k_est, period, no_signal, exp_edges(16), exp_k(16));
    end
  endtask

  // Signal starts from a known edge so the arming edge and the DONE cycle
  // can be predicted; extra starts in GATE and DONE must be ignored.
  task automatic test_start_ignored();
    bit seen;
    int s;
    set_level(1'b0);
    repeat (5) tick();
    pulse_start();
    repeat (3) tick();
    set_periodic(16);
    s = cyc + 1;
    while (cyc < s + 100) tick();
    pulse_start();
    while (cyc < s + 259) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(4, seen);
    vectors++;
    if (!seen || (cyc - s) !== WIN + 4) begin
      miscompares++;
      $display("FAIL gate_latency: seen=%b at=%0d, expected %0d", seen, cyc - s, WIN + 4);
    end
    vectors++;
    if ({edge_cnt, k_est, period, no_signal} !== {exp_edges(16), exp_k(16), PW'(16), 1'b0}) begin
      miscompares++;
      $display("FAIL busy_start_result: edge=%0d k=%h per=%0d ns=%b, expected %0d %h 16 0",
               edge_cnt, k_est, period, no_signal, exp_edges(16), exp_k(16));
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_done: busy=%b valid=%b, expected 0 0", busy, valid);
    end
    wait_valid(2 * WIN, seen);
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL extra_valid: got 1 extra valid, expected none");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_periodic(16);
    repeat (8) tick();
    pulse_start();
    repeat (100) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if ({busy, valid, no_signal, edge_cnt, k_est, period} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b valid=%b ns=%b edge=%0d k=%h per=%0d, expected all 0",
               busy, valid, no_signal, edge_cnt, k_est, period);
    end
    tick();
    rst = 1'b0;
    wait_valid(2 * WIN, seen);
    vectors++;
    if (seen || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: valid_seen=%b busy=%b, expected 0 0", seen, busy);
    end
    tick();
    pulse_start();
    wait_valid(3 * WIN, seen);
    vectors++;
    if (!seen || {edge_cnt, k_est, period, no_signal} !== {exp_edges(16), exp_k(16), PW'(16), 1'b0}) begin
      miscompares++;
      $display("FAIL after_reset_meas: seen=%b edge=%0d k=%h per=%0d ns=%b, expected %0d %h 16 0",
               seen, edge_cnt, k_est, period, no_signal, exp_edges(16), exp_k(16));
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    set_periodic(2);
    repeat (8) tick();
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_valid(2 * WIN + 20, seen);
      vectors++;
      if (!seen || {edge_cnt, k_est, period, no_signal} !== {exp_edges(2), exp_k(128), PW'(2), 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_round%0d: seen=%b edge=%0d k=%h per=%0d ns=%b, expected %0d %h 2 0",
                 r, seen, edge_cnt, k_est, period, no_signal, exp_edges(2), exp_k(128));
      end
      @(negedge clk);
      vectors++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_pulse%0d: valid=%b busy=%b, expected 0 1", r, valid, busy);
      end
    end
    continuous = 1'b0;
    wait_valid(2 * WIN + 20, seen);
    @(negedge clk);
    vectors++;
    if (!seen || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_stop: final_valid=%b busy=%b, expected 1 0", seen, busy);
    end
  endtask

  task automatic test_period37();
    bit seen;
    set_periodic(37);
    repeat (8) tick();
    continuous = 1'b1;
    wait_valid(3 * WIN, seen);
    vectors++;
    if (!seen || {edge_cnt, k_est, period, no_signal} !== {exp_edges(37), exp_k(int'(exp_edges(37))), PW'(37), 1'b0}) begin
      miscompares++;
      $display("FAIL p37_first: seen=%b edge=%0d k=%h per=%0d ns=%b, expected %0d %h 37 0",
               seen, edge_cnt, k_est, period, no_signal, exp_edges(37), exp_k(int'(exp_edges(37))));
    end
    repeat (100) tick();
    continuous = 1'b0;
    wait_valid(3 * WIN, seen);
    vectors++;
    if (!seen || {edge_cnt, k_est, period, no_signal} !== {exp_edges(37), exp_k(int'(exp_edges(37))), PW'(37), 1'b0}) begin
      miscompares++;
      $display("FAIL p37_final: seen=%b edge=%0d k=%h per=%0d ns=%b, expected %0d 37 0",
               seen, edge_cnt, k_est, period, no_signal, exp_edges(37));
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL p37_idle: busy=%b, expected 0", busy);
    end
    wait_valid(2 * WIN, seen);
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL p37_extra: got valid after continuous dropped, expected none");
    end
  endtask

  task automatic test_random();
    bit seen;
    int p;
    for (int n = 0; n < 8; n++) begin
      p = int'($urandom_range(70, 2));
      set_periodic(p);
      repeat (int'($urandom_range(40, 8))) tick();
      pulse_start();
      wait_valid(3 * WIN, seen);
      vectors++;
      if (!seen || {edge_cnt, k_est, period, no_signal} !== {exp_edges(p), exp_k(int'(exp_edges(p))), PW'(p), 1'b0}) begin
        miscompares++;
        $display("FAIL random_p%0d: seen=%b edge=%0d k=%h per=%0d ns=%b, expected %0d %h %0d 0",
                 p, seen, edge_cnt, k_est, period, no_signal, exp_edges(p), exp_k(int'(exp_edges(p))), p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_signal();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_period37();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
